// File: rtl/signal_mux_pkg.sv
// Shared constants, FSM encoding and sizing helper for the correlator input selector.
// Pure definitions; no timing or flow-control behaviour of its own.
package signal_mux_pkg;

  localparam int DEF_NUM_SRC   = 12;
  localparam int DEF_SRC_W     = 2;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_SEL_W     = 4;
  localparam int DEF_BLANK_CYC = 4;

  // Select code reserved for the wide complex source sits just above the narrow codes.
  localparam int EXT_CODE = DEF_NUM_SRC;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } mux_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/signal_mux_switch_fsm.sv
// Source-switch control: holds requests until an epoch, then blanks for BLANK_CYC cycles.
// sel_cur changes one clock after the accepting epoch; no backpressure, requests are never stalled.
module signal_mux_switch_fsm
  import signal_mux_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_wr,
  input  logic             epoch,
  output logic [SEL_W-1:0] sel_cur,
  output logic             blank,
  output logic             busy,
  output logic             sel_err
);

  localparam int               CNT_W    = cnt_width(BLANK_CYC);
  localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mux_state_e       state_q, state_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             sel_err_q, sel_err_d;
  logic             req_legal;
  logic             wr_ok;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    sel_cur_d = sel_cur_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    sel_err_d = sel_err_q;

    req_legal = (sel_req <= MAX_CODE);
    wr_ok     = sel_wr & req_legal;

    if (sel_wr) begin
      sel_err_d = ~req_legal;
    end

    case (state_q)
      ST_RUN: begin
        // An epoch arriving with the request is deliberately not honoured here.
        if (wr_ok && (sel_req != sel_cur_q)) begin
          pend_d  = sel_req;
          state_d = ST_PEND;
        end
      end

      ST_PEND: begin
        if (wr_ok && (sel_req == sel_cur_q)) begin
          state_d = ST_RUN;
        end else if (epoch) begin
          sel_cur_d = wr_ok ? sel_req : pend_q;
          pend_d    = wr_ok ? sel_req : pend_q;
          cnt_d     = CNT_LOAD;
          flag_d    = 1'b0;
          state_d   = ST_BLANK;
        end else if (wr_ok) begin
          pend_d = sel_req;
        end
      end

      ST_BLANK: begin
        cnt_d = cnt_q - CNT_ONE;
        if (wr_ok) begin
          pend_d = sel_req;
          flag_d = 1'b1;
        end
        if (cnt_q <= CNT_ONE) begin
          cnt_d  = '0;
          flag_d = 1'b0;
          // A request landing on the final blank cycle still counts.
          if ((flag_q || wr_ok) && (pend_d != sel_cur_q)) begin
            state_d = ST_PEND;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      pend_q    <= '0;
      sel_cur_q <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      sel_cur_q <= sel_cur_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_cur = sel_cur_q;
  assign blank   = (state_q == ST_BLANK);
  assign busy    = (state_q != ST_RUN);
  assign sel_err = sel_err_q;

endmodule

// File: rtl/signal_mux_sync.sv
// Correlator input selector: narrow or wide source, extended to OUT_W, epoch-synchronised switching.
// One-cycle registered datapath; no backpressure, outputs zero and invalid while blanking.
module signal_mux_sync
  import signal_mux_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int SRC_W     = DEF_SRC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                     pclk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*SRC_W-1:0] src_data,
  input  logic [OUT_W-1:0]         ext_re,
  input  logic [OUT_W-1:0]         ext_im,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_wr,
  input  logic                     epoch,
  input  logic                     signext,
  output logic [OUT_W-1:0]         out_re,
  output logic [OUT_W-1:0]         out_im,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         sel_cur,
  output logic                     busy,
  output logic                     sel_err
);

  localparam logic [SEL_W-1:0] EXT_SEL = SEL_W'(NUM_SRC);

  logic             blank;
  logic [SRC_W-1:0] narrow_raw;
  logic [OUT_W-1:0] narrow_ext;
  logic [OUT_W-1:0] out_re_q, out_re_d;
  logic [OUT_W-1:0] out_im_q, out_im_d;
  logic             out_valid_q, out_valid_d;

  signal_mux_switch_fsm #(
    .NUM_SRC   (NUM_SRC),
    .SEL_W     (SEL_W),
    .BLANK_CYC (BLANK_CYC)
  ) u_switch_fsm (
    .pclk    (pclk),
    .reset_n (reset_n),
    .sel_req (sel_req),
    .sel_wr  (sel_wr),
    .epoch   (epoch),
    .sel_cur (sel_cur),
    .blank   (blank),
    .busy    (busy),
    .sel_err (sel_err)
  );

  always_comb begin
    narrow_raw = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_cur == SEL_W'(k)) begin
        narrow_raw = src_data[k*SRC_W +: SRC_W];
      end
    end
    narrow_ext = {{(OUT_W-SRC_W){signext & narrow_raw[SRC_W-1]}}, narrow_raw};
  end

  always_comb begin
    out_re_d    = '0;
    out_im_d    = '0;
    out_valid_d = 1'b0;
    // Zeros during blanking keep partially switched samples out of the accumulators.
    if (!blank) begin
      out_valid_d = 1'b1;
      if (sel_cur == EXT_SEL) begin
        out_re_d = ext_re;
        out_im_d = ext_im;
      end else begin
        out_re_d = narrow_ext;
        out_im_d = narrow_ext;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_valid = out_valid_q;

endmodule
